// File: rtl/regfile_if.sv
// Register-file bus: one write-back port and two decode read ports.
// The master drives indices, enables and write data; the register file
// (slave) returns the combinational read data.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/regfile.sv
// General-purpose register file: NREG x DATA_W storage, r0 hardwired to zero,
// synchronous write from write-back, two zero-latency read ports for decode.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a same-cycle
// write to an enabled read address is forwarded to that read port.
// rst is asynchronous and active-low; it clears storage and the write count.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic        clk,
    input  logic        rst,
    regfile_if.slave    bus,
    output logic [31:0] wr_count
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] mem [NREG];
    logic [31:0]       wr_cnt;
    logic              commit;

    // A write only counts when it targets a real register; r0 writes vanish.
    assign commit = bus.we && (bus.waddr != '0);

    // Storage: async clear of every entry, otherwise commit on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // Committed-write counter; wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        wr_cnt <= '0;
        else if (commit) wr_cnt <= wr_cnt + 32'd1;
    end

    assign wr_count = wr_cnt;

    // Read port 1: reset, r0, bypass, stored value, disabled -- in that order.
    always_comb begin
        bus.rdata1 = '0;
        if (!rst || bus.raddr1 == '0)
            bus.rdata1 = '0;
        else if (BYPASS && bus.re1 && commit && bus.waddr == bus.raddr1)
            bus.rdata1 = bus.wdata;
        else if (bus.re1)
            bus.rdata1 = mem[bus.raddr1];
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        bus.rdata2 = '0;
        if (!rst || bus.raddr2 == '0)
            bus.rdata2 = '0;
        else if (BYPASS && bus.re2 && commit && bus.waddr == bus.raddr2)
            bus.rdata2 = bus.wdata;
        else if (bus.re2)
            bus.rdata2 = mem[bus.raddr2];
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_regfile;
    logic        clk;
    logic        rst;
    logic [31:0] wr_count;

    regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ref_mem [32];
    logic [31:0] ref_cnt;
    int          checks;
    int          errs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic en, input logic [4:0] a);
        if (!rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (en && bus.we && bus.waddr == a) return bus.wdata;
`endif
        if (en) return ref_mem[a];
        return 32'h0;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        ref_cnt = 32'h0;
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (!v) ref_clear();
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        bus.we = we; bus.waddr = wa; bus.wdata = wd;
        bus.re1 = r1; bus.raddr1 = a1; bus.re2 = r2; bus.raddr2 = a2;
    endtask

    // Called at a negedge with inputs applied: check reads, clock, check count.
    task automatic step(input string tag);
        #2;
        check({tag, ".rd1"}, bus.rdata1, ref_read(bus.re1, bus.raddr1));
        check({tag, ".rd2"}, bus.rdata2, ref_read(bus.re2, bus.raddr2));
        @(posedge clk);
        if (rst && bus.we && bus.waddr != 5'd0) begin
            ref_mem[bus.waddr] = bus.wdata;
            ref_cnt = ref_cnt + 32'd1;
        end
        @(negedge clk);
        check({tag, ".cnt"}, wr_count, ref_cnt);
    endtask

    initial begin
        checks = 0;
        errs   = 0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_rst(1'b0);
        #1;
        check("reset.rd1", bus.rdata1, 32'h0);
        check("reset.cnt", wr_count, 32'h0);
        @(negedge clk);
        set_rst(1'b1);

        // 1: async reset clears r5 without any clock edge
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0);
        step("t1.wr");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        check("t1.pre", bus.rdata1, 32'h1234);
        set_rst(1'b0);
        #1;
        check("t1.async_rd", bus.rdata1, 32'h0);
        check("t1.async_cnt", wr_count, 32'h0);
        #1;
        set_rst(1'b1);
        #1;
        check("t1.after_rd", bus.rdata1, 32'h0);
        @(negedge clk);
        step("t1.rd");

        // 2: basic write then read; disabled port reads 0
        drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        step("t2.wr");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7);
        step("t2.rd");
        check("t2.val", bus.rdata1, 32'hDEADBEEF);
        check("t2.off", bus.rdata2, 32'h0);
        check("t2.cnt1", wr_count, 32'h1);

        // 3: r0 write discarded, r0 reads 0 both cycles
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        check("t3.same", bus.rdata1, 32'h0);
        step("t3.wr");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
        #1;
        check("t3.next", bus.rdata1, 32'h0);
        check("t3.cnt", wr_count, 32'h1);
        step("t3.rd");

        // 4: same-cycle RAW on r3 (old 0x11, new 0x22)
        drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
        step("t4.pre");
        drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 1'b1, 5'd3);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t4.byp1", bus.rdata1, 32'h22);
        check("t4.byp2", bus.rdata2, 32'h22);
`else
        check("t4.old1", bus.rdata1, 32'h11);
        check("t4.old2", bus.rdata2, 32'h11);
`endif
        step("t4.wr");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
        #1;
        check("t4.new1", bus.rdata1, 32'h22);
        check("t4.new2", bus.rdata2, 32'h22);
        step("t4.rd");

        // 5: reset held across a write edge suppresses the write
        drive(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        set_rst(1'b0);
        step("t5.wr");
        set_rst(1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
        #1;
        check("t5.r9", bus.rdata1, 32'h0);
        check("t5.cnt", wr_count, 32'h0);
        step("t5.rd");

        // 6: counter wrap from a preloaded value
        force dut.wr_cnt = 32'hFFFFFFFE;
        #1;
        release dut.wr_cnt;
        ref_cnt = 32'hFFFFFFFE;
        #1;
        check("t6.preload", wr_count, 32'hFFFFFFFE);
        drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
        step("t6.w1");
        check("t6.c1", wr_count, 32'hFFFFFFFF);
        drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0);
        step("t6.w2");
        check("t6.c2", wr_count, 32'h0);
        drive(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 1'b0, 5'd0);
        step("t6.w3");
        check("t6.c3", wr_count, 32'h1);

        // Random traffic with small address range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, a1, a2;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a1 = wa;
            if ($urandom_range(0, 3) == 0) a2 = wa;
            drive(1'($urandom), wa, $urandom, 1'($urandom), a1,
                  ($urandom_range(0, 3) != 0), a2);
            set_rst($urandom_range(0, 49) != 0);
            step("rand");
        end
        set_rst(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", checks, -1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file: the write-side consumer of the execute stage's result interface (waddr/we/wdata, delivered through the write-back path).
- Serves the decode stage through two combinational read ports.
- 32 x 32-bit storage; register 0 hardwired to zero.
- Synchronous write with optional same-cycle write-to-read bypass.

Parameters:
DATA_W, 32, data width of each register (matches RegBus)
ADDR_W, 5, register address width (matches RegAddrBus)
NREG, 32, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  system clock; all writes on rising edge
rst  input  1  asynchronous reset, active-low; 0 = reset asserted
we  input  1  write enable from write-back
waddr  input  ADDR_W  write register index
wdata  input  DATA_W  write data
re1  input  1  read port 1 enable
raddr1  input  ADDR_W  read port 1 index
rdata1  output  DATA_W  read port 1 data
re2  input  1  read port 2 enable
raddr2  input  ADDR_W  read port 2 index
rdata2  output  DATA_W  read port 2 data
wr_count  output  32  number of committed writes since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - All NREG registers cleared to 0 immediately, independent of clk.
  - wr_count cleared to 0.
  - rdata1/rdata2 forced to 0 combinationally while rst=0.
  - Writes are ignored on any edge where rst=0.
- Write:
  - On clk rising edge with rst=1, we=1 and waddr!=0: reg[waddr] <= wdata and wr_count <= wr_count+1.
  - A write with waddr=0 is discarded and does not increment wr_count.
  - we=0 leaves storage and wr_count unchanged.
- wr_count wraps from 0xFFFFFFFF to 0 with no flag.
- Read, combinational and zero latency, evaluated per port in this priority:
  1. rst=0 -> 0.
  2. raddrN=0 -> 0, regardless of we/waddr.
  3. Bypass: if REGFILE_BYPASS_EN is defined, reN=1, we=1 and waddr==raddrN -> wdata (same-cycle forwarding).
  4. reN=1 -> reg[raddrN].
  5. reN=0 -> 0.
- Both ports may read the same index in the same cycle; each port follows the rules independently.
- Read and write to the same index in the same cycle without bypass: read returns the old value; the new value is visible from the next cycle.
- Reset mid-operation:
  - Asserting rst in the same cycle as a write suppresses the write.
  - Deasserting rst is synchronised by the integrator; the first write honoured is the first rising edge with rst=1.
- No X on outputs for any input combination after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write data is forwarded to any read port whose enabled address matches a non-zero waddr with we=1.
  - Decode sees the value being written back without a stall.
- Undefined: no forwarding; read ports always return stored contents.
  - The pipeline must stall one cycle on write-back/decode RAW hazards.
- Storage, reset, wr_count and the register-0 rules are identical in both builds.

Test Plan:
1. Reset clears storage: with rst=0 mid-simulation, asynchronously (no clk edge), after writing 0x1234 to r5 -> rdata1 reads 0 from r5 after release; wr_count=0.
2. Basic write/read: write 0xDEADBEEF to r7 at edge N -> re1=1, raddr1=7 gives 0xDEADBEEF from cycle N+1; re2=0 gives rdata2=0; wr_count=1.
3. Register 0 rules: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 at raddr1=0 stays 0 both same-cycle and next cycle; wr_count unchanged.
4. Same-cycle RAW on r3, old value 0x11, writing 0x22, both ports reading r3:
   - With REGFILE_BYPASS_EN: rdata1=rdata2=0x22 in the write cycle.
   - Without REGFILE_BYPASS_EN: both read 0x11 in the write cycle and 0x22 in the next cycle.
5. Reset vs write collision: rst driven 0 during a cycle with we=1, waddr=9, wdata=0xA5A5A5A5 -> after release r9 reads 0 and wr_count=0.
6. Counter wrap: preload by forcing wr_count to 0xFFFFFFFE, then perform 3 valid writes -> wr_count sequence is 0xFFFFFFFF, 0, 1.
